// File: rtl/padtest_pkg.sv
// rtl/padtest_pkg.sv - shared widths, mode encoding and helpers for the pad test core
package padtest_pkg;

  localparam int PAD_W  = 14;
  localparam int MODE_W = 2;
  localparam int DATA_W = PAD_W - MODE_W;

  typedef enum logic [MODE_W-1:0] {
    MODE_LOOP  = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_EDGE  = 2'd3
  } padtest_mode_e;

  localparam logic [PAD_W-1:0] WALK_INIT = 14'h0001;
  localparam logic [PAD_W-1:0] EDGE_MAX  = 14'h3FFF;

  function automatic logic [PAD_W-1:0] rotl1(input logic [PAD_W-1:0] v);
    return {v[PAD_W-2:0], v[PAD_W-1]};
  endfunction

endpackage

// File: rtl/padtest_sync.sv
// rtl/padtest_sync.sv - multi-stage flop synchroniser for asynchronous pad inputs
module padtest_sync #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/padtest_core.sv
// rtl/padtest_core.sv - synchronised pad datapath with loopback/walk/count/edge test modes
// Optional: define PADTEST_PARITY_EN to drive even parity of uo_out[12:0] on uo_out[13].
module padtest_core
  import padtest_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MODE_STABLE = 8,
  parameter int PRESC_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAD_W-1:0] ui_in,
  output logic [PAD_W-1:0] uo_out
);

  localparam int STAB_W  = $clog2(MODE_STABLE + 1);
  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [STAB_W-1:0]  STAB_MAX   = STAB_W'(MODE_STABLE);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

  logic [PAD_W-1:0]   ui_s;
  logic [MODE_W-1:0]  req_code;
  logic [MODE_W-1:0]  code_prev;
  logic [STAB_W-1:0]  stab;
  logic [PRESC_W-1:0] presc;
  logic [PAD_W-1:0]   walk;
  logic [PAD_W-1:0]   cnt;
  logic [PAD_W-1:0]   edges;
  logic               d0_prev;
  padtest_mode_e      mode;
  logic               commit;
  logic               tick;
  logic               rise;
  logic [PAD_W-1:0]   uo_next;

  padtest_sync #(.WIDTH(PAD_W), .DEPTH(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in),
    .q     (ui_s)
  );

  assign req_code = ui_s[PAD_W-1 -: MODE_W];
  assign commit   = (req_code != mode) && (stab == STAB_MAX);
  assign tick     = (presc == PRESC_LAST);
  assign rise     = ui_s[0] & ~d0_prev;

  always_comb begin
    uo_next = '0;
    unique case (mode)
      MODE_LOOP:  uo_next = {mode, ui_s[DATA_W-1:0]};
      MODE_WALK:  uo_next = walk;
      MODE_COUNT: uo_next = cnt;
      MODE_EDGE:  uo_next = edges;
    endcase
`ifdef PADTEST_PARITY_EN
    uo_next[PAD_W-1] = ^uo_next[PAD_W-2:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode      <= MODE_LOOP;
      code_prev <= '0;
      stab      <= '0;
      presc     <= '0;
      walk      <= WALK_INIT;
      cnt       <= '0;
      edges     <= '0;
      d0_prev   <= 1'b0;
      uo_out    <= '0;
    end else begin
      uo_out    <= uo_next;
      d0_prev   <= ui_s[0];
      code_prev <= req_code;
      if (req_code != code_prev) stab <= '0;
      else if (stab != STAB_MAX) stab <= stab + 1'b1;

      // A commit overrides any tick or edge seen in the same cycle.
      if (commit) begin
        mode  <= padtest_mode_e'(req_code);
        presc <= '0;
        walk  <= WALK_INIT;
        cnt   <= '0;
        edges <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        unique case (mode)
          MODE_LOOP:  ;
          MODE_WALK:  if (tick) walk <= rotl1(walk);
          MODE_COUNT: if (tick) cnt <= cnt + 1'b1;
          MODE_EDGE:  if (rise && edges != EDGE_MAX) edges <= edges + 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_padtest_core.sv
// tb/tb_padtest_core.sv - randomized self-checking bench for padtest_core against a behavioural model
module tb_padtest_core;

  localparam int SYNC = 2;
  localparam int MS   = 8;

  int div [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] ui_in;
  logic [13:0] uo0, uo1;

  padtest_core #(.SYNC_STAGES(SYNC), .MODE_STABLE(MS), .PRESC_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo0)
  );

  padtest_core #(.SYNC_STAGES(SYNC), .MODE_STABLE(MS), .PRESC_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: pipeline history, stability age, walk as a bit position, plain integers.
  logic [13:0] hist [SYNC];
  int m_code_prev = 0, m_stab = 0, m_mode = 0, m_d0prev = 0;
  int m_presc [2] = '{0, 0};
  int m_pos   [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int m_edges [2] = '{0, 0};
  logic [13:0] m_uo [2] = '{14'h0, 14'h0};

  function automatic logic [13:0] present(input logic [13:0] v);
    logic [13:0] r;
    r = v;
`ifdef PADTEST_PARITY_EN
    r[13] = ($countones(v[12:0]) % 2) == 1;
`endif
    return r;
  endfunction

  task automatic step();
    logic [13:0] s, v;
    int code;
    bit rise, commit, tick;
    @(posedge clk);
    s = hist[SYNC-1];
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) hist[i] = '0;
      m_code_prev = 0; m_stab = 0; m_mode = 0; m_d0prev = 0;
      for (int k = 0; k < 2; k++) begin
        m_presc[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_edges[k] = 0; m_uo[k] = '0;
      end
    end else begin
      code   = int'(s[13:12]);
      rise   = (s[0] == 1'b1) && (m_d0prev == 0);
      commit = (code != m_mode) && (m_stab == MS);
      for (int k = 0; k < 2; k++) begin
        case (m_mode)
          0:       v = 14'(m_mode * 4096 + int'(s[11:0]));
          1:       v = 14'(1 << m_pos[k]);
          2:       v = 14'(m_cnt[k]);
          default: v = 14'(m_edges[k]);
        endcase
        m_uo[k] = present(v);
        if (commit) begin
          m_presc[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_edges[k] = 0;
        end else begin
          tick = (m_presc[k] == div[k] - 1);
          m_presc[k] = tick ? 0 : m_presc[k] + 1;
          if (m_mode == 1 && tick) m_pos[k] = (m_pos[k] + 1) % 14;
          if (m_mode == 2 && tick) m_cnt[k] = (m_cnt[k] + 1) % 16384;
          if (m_mode == 3 && rise && m_edges[k] < 16383) m_edges[k]++;
        end
      end
      if (commit) m_mode = code;
      if (code != m_code_prev) m_stab = 0;
      else if (m_stab < MS) m_stab++;
      m_code_prev = code;
      m_d0prev    = int'(s[0]);
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ui_in;
    end
    @(negedge clk);
    check("uo_div4", uo0, m_uo[0]);
    check("uo_div1", uo1, m_uo[1]);
  endtask

  logic [13:0] prev1;
  logic [13:0] seen_wrap;
  int hold;

  initial begin
    rst_n = 1'b0;
    ui_in = '0;
    repeat (3) begin
      step();
      check("rst_uo", uo0, 14'h0000);
    end

    // Loopback latency
    rst_n = 1'b1;
    ui_in = 14'h0ABC;
    step();
    step();
    check("loop_early", uo0, 14'h0000);
    step();
    check("loop_lat3", uo0, present(14'h0ABC));
    repeat (10) begin
      ui_in = {2'b00, 12'($urandom)};
      step();
    end

    // Walking one, then a short mode glitch that must not commit
    repeat (80) begin
      ui_in = {2'b01, 12'($urandom)};
      step();
    end
    repeat (5) begin
      ui_in = {2'b10, 12'($urandom)};
      step();
    end
    repeat (40) begin
      ui_in = {2'b01, 12'($urandom)};
      step();
    end

    // Reset mid-walk, loopback resumes
    rst_n = 1'b0;
    ui_in = 14'h0007;
    step();
    check("rst_mid", uo0, 14'h0000);
    rst_n = 1'b1;
    repeat (3) step();
    check("loop_after_rst", uo0, present(14'h0007));
`ifdef PADTEST_PARITY_EN
    check("parity_bit", {13'h0, uo0[13]}, 14'h0001);
`endif

    // Counter wrap on the divide-by-1 instance
    ui_in = {2'b10, 12'h000};
    repeat (12) step();
    seen_wrap = '0;
    prev1 = uo1;
    repeat (16400) begin
      step();
      if (prev1 == 14'h3FFF && uo1 == 14'h0000) seen_wrap = 14'h0001;
      prev1 = uo1;
    end
    check("cnt_wrap", seen_wrap, 14'h0001);

    // Edge count and saturation
    ui_in = {2'b11, 12'h000};
    repeat (12) step();
    repeat (5) begin
      ui_in[0] = 1'b1; step();
      ui_in[0] = 1'b0; step();
    end
    repeat (4) step();
    check("edge5", uo0, present(14'h0005));
    repeat (20000) begin
      ui_in[0] = 1'b1; step();
      ui_in[0] = 1'b0; step();
    end
    repeat (4) step();
    check("edge_sat", uo0, present(14'h3FFF));
    check("edge_sat1", uo1, present(14'h3FFF));

    // Random mode codes, hold lengths, data and occasional resets
    repeat (40) begin
      hold = $urandom_range(1, 16);
      ui_in[13:12] = 2'($urandom_range(0, 3));
      repeat (hold) begin
        ui_in[11:0] = 12'($urandom);
        rst_n = ($urandom_range(0, 49) != 0);
        step();
      end
      rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/padtest_core.md
Name: padtest_core

Overview:
- Core-side test logic between the 14 input pads (pad-to-core) and the 14 output pads (core-to-pad) of the 32-pad QNC padframe.
- Replaces the direct input-to-output wire with a synchronised, registered datapath.
- Provides four selectable bring-up modes for probing the pads on the tester: loopback, walking-one, counter, edge count.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on the pad inputs (≥2).
- MODE_STABLE, 8, consecutive cycles a new mode code must hold before it is committed (≥1).
- PRESC_DIV, 4, clock cycles per pattern tick (≥1; 1 = tick every cycle).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  synchronous, active-low reset.
- ui_in  input  14  pad-to-core bits, asynchronous to clk.
- uo_out  output  14  core-to-pad bits, fully registered.

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- **Input synchronisation**
  - ui_in passes through SYNC_STAGES flops, producing ui_s.
  - ui_s[13:12] is the requested mode. ui_s[11:0] is data.
- **Mode filter**
  - Stability counter, 0..MODE_STABLE, saturating.
  - It clears whenever ui_s[13:12] differs from the previous cycle's value.
  - When ui_s[13:12] ≠ committed mode and the counter reaches MODE_STABLE, that code is committed.
  - Commit pulse (1 cycle) sets: prescaler=0, walk=14'h0001, cnt=0, edges=0.
  - Reset commits mode 0.
- **Prescaler**
  - Counts 0..PRESC_DIV-1; tick asserted when it equals PRESC_DIV-1, then wraps to 0.
- **Modes**
  - 0 LOOP: next uo_out = {mode, ui_s[11:0]}.
  - 1 WALK: on tick, walk rotates left by 1; bit13 wraps to bit0. uo_out = walk.
  - 2 COUNT: on tick, cnt += 1, 14-bit modulo (16383 → 0). uo_out = cnt.
  - 3 EDGE: edges += 1 on each rising edge of ui_s[0] (previous 0, current 1).
    - Saturates at 14'h3FFF. uo_out = edges.
    - Prescaler is not used.
- **Output**
  - uo_out is registered.
  - Internal state update at edge N appears on uo_out at edge N+1.
  - LOOP latency from ui_in to uo_out: SYNC_STAGES+1 cycles.
- **Simultaneous events**
  - A commit in the same cycle as a tick or an edge: the commit wins and the counters load their initial values.
  - Mode counters not currently selected hold their values.
- **Reset**
  - Applies at any time, including mid-pattern or mid-filter.
  - Next edge: all sync flops, filter counter, prescaler, cnt and edges = 0; walk = 14'h0001; committed mode = 0; uo_out = 14'h0000.

Optional Feature:
- Macro: PADTEST_PARITY_EN.
- Defined: uo_out[13] is replaced by the even-parity bit of the next uo_out[12:0]. Computed combinationally before the output register, so latency is unchanged.
  - In WALK mode the walk still rotates through all 14 positions; only the driven pad bit 13 shows parity.
- Undefined: uo_out[13] is the mode-dependent bit as above.

Decomposition:
- **padtest_pkg**
  - PAD_W = 14.
  - MODE_W = 2.
  - Enum padtest_mode_e {MODE_LOOP, MODE_WALK, MODE_COUNT, MODE_EDGE}.
  - WALK_INIT = 14'h0001.
- **padtest_sync** sub-module
  - Parameterised width and depth, synchronous active-low reset.
  - Instantiated once for the 14-bit ui_in.

Test Plan:
1. Reset, then hold ui_in=14'h0ABC (mode 0) → uo_out=14'h0ABC exactly SYNC_STAGES+1=3 cycles after ui_in is applied; uo_out=0 during reset.
2. ui_in[13:12]=01 held 8+ cycles, PRESC_DIV=4 → after commit, uo_out steps 0001, 0002, 0004 … 2000, 0001, one step every 4 cycles.
3. Mode 2 with cnt forced near wrap (run 16383 ticks, PRESC_DIV=1) → uo_out goes 3FFF → 0000.
4. Mode 3, toggle ui_in[0] for 5 rising edges → uo_out=5. Then 20000 further edges → uo_out stays 3FFF.
5. Mode code glitch: ui_in[13:12] set to 10 for 5 cycles, then back to 01 → no commit, walk sequence continues uninterrupted.
6. Assert rst_n=0 mid-WALK for one cycle → uo_out=0 next cycle, then loopback mode resumes. With PADTEST_PARITY_EN, loopback of 14'h0007 gives uo_out[13]=1.
